// File: rtl/sample_packer.sv
// rtl/sample_packer.sv - packs 1/2/4-channel quantized samples into 16-bit words through a 4-deep FIFO
//
// Ports:
//   source_clk      sample clock, all flops on rising edge
//   source_reset_n  asynchronous active-low reset
//   enable          packing enable; mode is latched on its rising edge
//   mode            0 = 1 ch, 1 = 2 ch, 2 = 4 ch, 3 = treated as 0
//   sym_in          one 4-bit symbol per channel, ch1 in [15:12]
//   overflow_clear  pulse clearing overflow and drop_count
//   out_data        packed word at FIFO head (0 when empty)
//   out_valid       FIFO not empty
//   out_ready       consumer accepts the head word
//   overflow        sticky: a completed word was dropped
//   drop_count      saturating count of dropped words
module sample_packer (
    input  logic        source_clk,
    input  logic        source_reset_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] sym_in,
    input  logic        overflow_clear,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic [15:0] drop_count
);

    logic        enable_q;
    logic [1:0]  mode_q;
    logic [1:0]  slot_q;
    logic [11:0] partial_q;

    logic [15:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;

    logic [1:0]  mode_eff;
    logic [1:0]  last_slot;
    logic [15:0] word_next;
    logic        push;
    logic        pop;
    logic        full;
    logic        drop;
    logic        wr_en;

    // The first enabled cycle already captures a sample, so it must use the
    // incoming mode rather than the not-yet-updated latched one.
    assign mode_eff = (enable && !enable_q) ? ((mode == 2'd3) ? 2'd0 : mode) : mode_q;

    // Samples are shifted in from the right so the earliest one ends up in the MSBs.
    always_comb begin
        last_slot = 2'd0;
        word_next = sym_in;
        case (mode_eff)
            2'd0: begin
                last_slot = 2'd3;
                word_next = {partial_q[11:0], sym_in[15:12]};
            end
            2'd1: begin
                last_slot = 2'd1;
                word_next = {partial_q[7:0], sym_in[15:8]};
            end
            default: begin
                last_slot = 2'd0;
                word_next = sym_in;
            end
        endcase
    end

    assign push      = enable && (slot_q == last_slot);
    assign out_valid = (count != 3'd0);
    assign pop       = out_valid && out_ready;
    assign full      = (count == 3'd4);
    // When full, a simultaneous pop frees the slot the push writes into.
    assign drop      = push && full && !pop;
    assign wr_en     = push && !drop;
    assign out_data  = out_valid ? mem[rd_ptr] : 16'd0;

    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            enable_q  <= 1'b0;
            mode_q    <= 2'd0;
            slot_q    <= 2'd0;
            partial_q <= 12'd0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q) begin
                mode_q <= mode_eff;
            end
            if (!enable) begin
                slot_q    <= 2'd0;
                partial_q <= 12'd0;
            end else if (push) begin
                slot_q    <= 2'd0;
                partial_q <= 12'd0;
            end else begin
                slot_q    <= slot_q + 2'd1;
                partial_q <= word_next[11:0];
            end
        end
    end

    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= 16'd0;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= word_next;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + {2'd0, wr_en} - {2'd0, pop};
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clear) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (overflow_clear) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end
    end

endmodule

// File: tb/tb_sample_packer.sv
// tb/tb_sample_packer.sv - scoreboard bench for sample_packer with a behavioural packing model
module tb_sample_packer;

    logic        source_clk = 1'b0;
    logic        source_reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] sym_in = 16'd0;
    logic        overflow_clear = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic [15:0] drop_count;

    sample_packer dut (
        .source_clk     (source_clk),
        .source_reset_n (source_reset_n),
        .enable         (enable),
        .mode           (mode),
        .sym_in         (sym_in),
        .overflow_clear (overflow_clear),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 source_clk = ~source_clk;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_q[$];
    int m_cnt;
    bit m_ovf;
    int m_dc;
    bit m_en_prev;
    int m_mode;
    int m_samples[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_samples.delete();
        m_cnt = 0;
        m_ovf = 0;
        m_dc = 0;
        m_en_prev = 0;
        m_mode = 0;
    endtask

    // Scoreboard monitor: checks the head word whenever the consumer takes it.
    always @(negedge source_clk) begin
        if (source_reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h, expected no word", out_data);
            end else begin
                check("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    // Applies one cycle of stimulus, advances the model, then checks status.
    task automatic step(input bit en, input int md, input logic [15:0] sym, input bit rdy, input bit clr);
        int spw;
        int width;
        int word;
        bit push;
        bit pop;
        enable = en;
        mode = md[1:0];
        sym_in = sym;
        out_ready = rdy;
        overflow_clear = clr;
        push = 0;
        word = 0;
        if (en) begin
            if (!m_en_prev) m_mode = (md == 3) ? 0 : md;
            spw = 1 << (2 - m_mode);
            width = 16 / spw;
            m_samples.push_back(int'(sym) >> (16 - width));
            if (m_samples.size() == spw) begin
                for (int i = 0; i < spw; i++)
                    word = word | (m_samples[i] << (16 - width * (i + 1)));
                push = 1;
                m_samples.delete();
            end
        end else begin
            m_samples.delete();
        end
        m_en_prev = en;
        pop = (m_cnt > 0) && rdy;
        if (push && m_cnt == 4 && !pop) begin
            m_ovf = 1;
            m_dc = clr ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
        end else begin
            if (clr) begin
                m_ovf = 0;
                m_dc = 0;
            end
            if (push) begin
                exp_q.push_back(word[15:0]);
                m_cnt++;
            end
        end
        if (pop) m_cnt--;
        @(posedge source_clk);
        #1;
        check("out_valid", int'(out_valid), int'(m_cnt > 0));
        check("overflow", int'(overflow), int'(m_ovf));
        check("drop_count", int'(drop_count), m_dc);
    endtask

    task automatic do_reset();
        source_reset_n = 1'b0;
        enable = 1'b0;
        out_ready = 1'b0;
        overflow_clear = 1'b0;
        model_reset();
        @(posedge source_clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_drop_count", int'(drop_count), 0);
        source_reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Mode 1: A5 then 3C
        step(1, 1, 16'hA500, 1, 0);
        step(1, 1, 16'h3C00, 1, 0);
        check("m1_valid", int'(out_valid), 1);
        check("m1_data", int'(out_data), 16'hA53C);
        step(0, 1, 16'h0000, 1, 0);

        // Mode 0: nibbles 1,2,3,4
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 0, 16'(i << 12), 0, 0);
        check("m0_data", int'(out_data), 16'h1234);
        step(0, 0, 16'h0000, 1, 0);

        // Mode change ignored while enabled, then a partial mode-0 word discarded
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 2, 16'($urandom), 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 16'($urandom), 1, 0);
        step(0, 0, 16'h0000, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 16'($urandom), 1, 0);
        step(0, 0, 16'h0000, 1, 0);
        step(0, 0, 16'h0000, 1, 0);
        check("partial_not_emitted", int'(out_valid), 0);

        // Overflow: 10 words with consumer stalled
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 2, 16'(16'h1000 + i), 0, 0);
        check("ovf_drop_count", int'(drop_count), 6);
        check("ovf_flag", int'(overflow), 1);
        // Full FIFO with push+pop each cycle: no further drops
        for (int i = 0; i < 8; i++) step(1, 2, 16'(16'h2000 + i), 1, 0);
        check("pushpop_drop_count", int'(drop_count), 6);
        for (int i = 0; i < 5; i++) step(0, 2, 16'h0000, 1, 0);

        // Clear coinciding with a drop
        for (int i = 0; i < 4; i++) step(1, 2, 16'(16'h3000 + i), 0, 0);
        step(1, 2, 16'h3FFF, 0, 1);
        check("clr_drop_count", int'(drop_count), 1);
        check("clr_overflow", int'(overflow), 1);
        step(0, 2, 16'h0000, 0, 1);
        check("clr_only", int'(drop_count), 0);

        // Asynchronous reset mid-word with data buffered
        for (int i = 1; i <= 6; i++) step(1, 0, 16'(i << 12), 0, 0);
        #2;
        source_reset_n = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_data", int'(out_data), 0);
        do_reset();
        for (int i = 5; i <= 8; i++) step(1, 0, 16'(i << 12), 0, 0);
        check("post_rst_word", int'(out_data), 16'h5678);
        step(0, 0, 16'h0000, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) != 0), int'($urandom_range(0, 3)), 16'($urandom),
                 (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0));
        end

        for (int i = 0; i < 6; i++) step(0, 0, 16'h0000, 1, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 SHALL have port source_clk, input, 1 bit: sample clock (64 MHz); every flop is clocked on its rising edge.
REQ-002 SHALL have port source_reset_n, input, 1 bit: asynchronous reset, active-low.
REQ-003 SHALL have port enable, input, 1 bit: synchronous packing enable, driven from the streamer-enable control bit.
REQ-004 SHALL have port mode, input, 2 bits: packing mode. 0 = 1 channel; 1 = 2 channels; 2 = 4 channels; 3 = reserved, treated as 0.
REQ-005 SHALL have port sym_in, input, 16 bits: one quantized symbol set per cycle, 4 bits ({si,sq}) per channel. ch1 = [15:12], ch2 = [11:8], ch3 = [7:4], ch4 = [3:0].
REQ-006 SHALL have port overflow_clear, input, 1 bit: single-cycle pulse that clears overflow.
REQ-007 SHALL have port out_data, output, 16 bits: packed word at the FIFO head.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the word.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a word is dropped.
REQ-011 SHALL have port drop_count, output, 16 bits: count of dropped words, saturating.

Function
REQ-012 SHALL latch mode into mode_q on the cycle enable goes from 0 to 1; mode changes while enable=1 SHALL be ignored.
REQ-013 Samples per word SHALL be 4 in mode_q=0 (sym_in[15:12]), 2 in mode_q=1 (sym_in[15:8]) and 1 in mode_q=2 (sym_in[15:0]).
REQ-014 While enable=1, one sample SHALL be captured every cycle, starting on the cycle enable is first seen high.
REQ-015 The first-captured sample SHALL occupy the MSBs of the word, and each later sample SHALL occupy the next lower field.
REQ-016 A 2-bit slot counter SHALL count captured samples and wrap to 0 when a word completes; the completed word SHALL be pushed to the FIFO that same cycle.
REQ-017 When enable=0, the slot counter and partial word SHALL be cleared (the partial word is discarded), and words already in the FIFO SHALL continue to drain.
REQ-018 The FIFO SHALL be 4 words deep, first-in first-out.
REQ-019 A word pushed into an empty FIFO SHALL appear with out_valid=1 on the next cycle. Latency from the last sample's capture edge to out_valid is 1 cycle.
REQ-020 A pop SHALL occur on any edge where out_valid=1 and out_ready=1. out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 A push while the FIFO is full and no pop is occurring SHALL be dropped: the FIFO is unchanged, overflow is set to 1, and drop_count increments, saturating at 16'hFFFF.
REQ-022 A push and a pop in the same cycle while the FIFO is full SHALL both succeed, with occupancy staying at 4 and no drop.
REQ-023 A push and a pop in the same cycle while the FIFO is empty is impossible by construction (out_valid=0), so it SHALL need no handling.
REQ-024 overflow_clear=1 SHALL clear overflow and drop_count to 0; if a drop occurs in the same cycle, the drop SHALL win (overflow=1, drop_count=1).
REQ-025 FIFO read/write pointers SHALL be 2 bits and wrap modulo 4; a 3-bit occupancy counter SHALL range 0..4.
REQ-026 Sustained throughput SHALL be 1 word per cycle in mode 2, 1 per 2 cycles in mode 1 and 1 per 4 cycles in mode 0.

Reset
REQ-027 While source_reset_n=0, the block SHALL hold: out_data=0, out_valid=0, overflow=0, drop_count=0, FIFO empty (pointers 0, occupancy 0), slot counter 0, partial word 0, mode_q=0.
REQ-028 Assertion of source_reset_n mid-word or mid-drain SHALL discard all partial and buffered data immediately (asynchronously).
REQ-029 Deassertion of source_reset_n SHALL take effect on the next source_clk edge, and capture SHALL start on the first edge with enable=1.

Verification
REQ-030 Mode 1 test: stimulus is mode=1, enable rises, sym_in[15:8] = 8'hA5 then 8'h3C, out_ready=1. Required response: out_data=16'hA53C with out_valid=1 exactly 1 cycle after the 2nd capture edge.
REQ-031 Mode 0 test: stimulus is mode=0 with nibbles 1,2,3,4 on sym_in[15:12]. Required response: out_data=16'h1234.
REQ-032 Mode-change and partial-word test: stimulus is mode=2 latched, mode switched to 0 while enabled, then enable dropped after 3 mode-0-style samples. Required responses: every word is a full 16-bit sym_in (mode change ignored), and no partial word is ever emitted.
REQ-033 Overflow test: stimulus is mode=2 with out_ready=0 for 10 cycles. Required response: 4 words are held, overflow=1 and drop_count=6; then out_ready=1 drains the first 4 sym_in values in order.
REQ-034 Full push+pop test: stimulus is the FIFO full, out_ready=1 and mode=2 continuous. Required response: drop_count stays constant and out_data advances every cycle.
REQ-035 Clear/reset priority test: stimulus is overflow_clear pulsed in the same cycle as a drop. Required response: drop_count=1 and overflow=1. Stimulus is source_reset_n pulsed low mid-word. Required response: out_valid=0 immediately, and the next word contains only post-reset samples.
